// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the DMEM bus bridge.
package dmem_bridge_pkg;

    localparam int BE_W                = 4;
    localparam int TIMEOUT_CYCLES_DFLT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Bus access watchdog: a down-counter reloaded on clear, terminal count at zero.
// Instantiated by dmem_bus_bridge only when DMEM_TIMEOUT_EN is defined.
module dmem_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = RELOAD;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Zero here means TIMEOUT_CYCLES cycles have elapsed since the reload.
    assign expire_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/dmem_bus_bridge.sv
// Runs a single-cycle DMEM request from the control block as a valid/ready bus access,
// stalling the core until it completes. Optional watchdog: DMEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a load/store; latches the request fields
// REQ   | req_valid high, fields frozen until accepted
// WAIT  | load accepted, waiting for rsp_valid
// DONE  | stall released for one cycle so the core retires
module dmem_bus_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            mem_rd,
    input  logic [AW-1:0]   daddr,
    input  logic [BE_W-1:0] dwe,
    input  logic [31:0]     dwdata,
    output logic            stall,
    output logic [31:0]     drdata,
    output logic            bus_err,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [AW-1:0]   req_addr,
    output logic [BE_W-1:0] req_we,
    output logic [31:0]     req_wdata,
    input  logic            rsp_valid,
    input  logic [31:0]     rsp_rdata
);

    state_e          state_q;
    logic            req_valid_q;
    logic [AW-1:0]   req_addr_q;
    logic [BE_W-1:0] req_we_q;
    logic [31:0]     req_wdata_q;
    logic [31:0]     drdata_q;
    logic            bus_err_q;

    logic            is_store;
    logic            acc;
    logic [AW-1:0]   req_addr_d;
    logic [BE_W-1:0] req_we_d;
    logic            expire;

`ifdef SYNTHESIS
    assign is_store = |dwe;
`else
    // Non-memory instructions may leave dwe undriven; X there must not start a store.
    assign is_store = !$isunknown(dwe) && (|dwe);
`endif

    assign acc        = is_store | mem_rd;
    assign stall      = acc && (state_q != ST_DONE);
    assign req_addr_d = daddr & ~AW'(3);
    assign req_we_d   = is_store ? dwe : '0;

`ifdef DMEM_TIMEOUT_EN
    dmem_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  ((state_q == ST_IDLE) && acc),
        .enable_i ((state_q == ST_REQ) || (state_q == ST_WAIT)),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_we_q    <= '0;
            req_wdata_q <= '0;
            drdata_q    <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        req_addr_q  <= req_addr_d;
                        req_we_q    <= req_we_d;
                        req_wdata_q <= dwdata;
                        req_valid_q <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Stores are posted: no response phase after acceptance.
                    if (req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= (req_we_q != '0) ? ST_DONE : ST_WAIT;
                    end else if (expire) begin
                        req_valid_q <= 1'b0;
                        drdata_q    <= '0;
                        bus_err_q   <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (rsp_valid) begin
                        drdata_q <= rsp_rdata;
                        state_q  <= ST_DONE;
                    end else if (expire) begin
                        drdata_q  <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_valid = req_valid_q;
    assign req_addr  = req_addr_q;
    assign req_we    = req_we_q;
    assign req_wdata = req_wdata_q;
    assign drdata    = drdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Bench for dmem_bus_bridge: directed vector table, reset/timeout sequences, random accesses
// checked against an instruction-level memory model.
module tb_dmem_bus_bridge;

`ifdef DMEM_TIMEOUT_EN
    localparam int TO   = 8;
    localparam int MAXD = 2;
`else
    localparam int TO   = 64;
    localparam int MAXD = 5;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_rd = 1'b0;
    logic [31:0] daddr = '0;
    logic [3:0]  dwe = '0;
    logic [31:0] dwdata = '0;
    logic        stall, bus_err, req_valid;
    logic [31:0] drdata, req_addr, req_wdata;
    logic [3:0]  req_we;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_rdata = '0;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_drd = '0;
    logic        exp_err = 1'b0;
    logic [31:0] bus_mem [int];
    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;

    dmem_bus_bridge #(.AW(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .mem_rd(mem_rd), .daddr(daddr), .dwe(dwe), .dwdata(dwdata),
        .stall(stall), .drdata(drdata), .bus_err(bus_err), .req_valid(req_valid),
        .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    typedef struct {
        logic        ld;
        logic [31:0] a;
        logic [3:0]  we;
        logic [31:0] wd;
        int          rdly;
        int          sdly;
        int          exp_st;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] wd);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        int k = int'(a[31:2]);
        return bus_mem.exists(k) ? bus_mem[k] : dflt({a[31:2], 2'b00});
    endfunction

    // Instruction-level model: memory word semantics and expected stall count.
    task automatic ref_step(input logic ld, input logic [31:0] a, input logic [3:0] we,
                            input logic [31:0] wd, input int rdly, input int sdly, output int st);
        int k = int'(a[31:2]);
        logic [31:0] old = ref_mem.exists(k) ? ref_mem[k] : dflt({a[31:2], 2'b00});
        st = 0;
        if (we != 4'h0) begin
            ref_mem[k] = merge(old, we, wd);
            st = 2 + rdly;
        end else if (ld) begin
            exp_drd = old;
            st = 3 + rdly + sdly;
        end
    endtask

    // Presents one instruction and acts as the bus slave until the core is released.
    task automatic do_access(input string nm, input logic ld, input logic [31:0] a,
                             input logic [3:0] we, input logic [31:0] wd, input int rdly,
                             input int sdly, input int exp_st, input logic [31:0] exp_d);
        int st = 0, nreq = 0, rv = 0, post = 0;
        bit pend = 0, done = 0, fld_bad = 0;
        logic [31:0] paddr = '0, d = 'x;
        logic e = 1'bx, rvd = 1'bx;
        logic [3:0] wex = (we != 4'h0) ? we : 4'h0;
        mem_rd = ld; daddr = a; dwe = we; dwdata = wd;
        for (int c = 0; c < 300 && !done; c++) begin
            rsp_valid = 1'b0; rsp_rdata = $urandom; req_ready = 1'b0;
            if (pend) begin
                if (post == sdly) begin
                    rsp_valid = 1'b1; rsp_rdata = bus_rd(paddr); pend = 0;
                end
                post++;
            end else if (req_valid && ($urandom_range(0, 1) == 1)) begin
                rsp_valid = 1'b1;
            end
            if (req_valid) begin
                if (req_addr !== (a & ~32'h3) || req_we !== wex || req_wdata !== wd) fld_bad = 1;
                if (rv == rdly) begin
                    req_ready = 1'b1;
                    nreq++;
                    if (req_we == 4'h0) begin
                        pend = 1; post = 0; paddr = req_addr;
                    end else begin
                        bus_mem[int'(req_addr[31:2])] = merge(bus_rd(req_addr), req_we, req_wdata);
                    end
                end
                rv++;
            end
            #1;
            if (stall) st++;
            else begin
                done = 1; d = drdata; e = bus_err; rvd = req_valid;
            end
            @(negedge clk);
        end
        rsp_valid = 1'b0; req_ready = 1'b0;
        chk({nm, ".finished"}, 32'(done), 32'd1);
        chk({nm, ".stall_cycles"}, 32'(st), 32'(exp_st));
        chk({nm, ".drdata"}, d, exp_d);
        chk({nm, ".requests"}, 32'(nreq), (ld || we != 4'h0) ? 32'd1 : 32'd0);
        chk({nm, ".req_fields"}, 32'(fld_bad), 32'd0);
        chk({nm, ".bus_err"}, 32'(e), 32'(exp_err));
        chk({nm, ".valid_in_done"}, 32'(rvd), 32'd0);
    endtask

    initial begin
        int st;
        bit s_seen, v_seen, done;
        bus_mem[32'h104 >> 2] = 32'hCAFEF00D; ref_mem[32'h104 >> 2] = 32'hCAFEF00D;
        bus_mem[32'h200 >> 2] = 32'h55667788; ref_mem[32'h200 >> 2] = 32'h55667788;
        bus_mem[32'h040 >> 2] = 32'h01020304; ref_mem[32'h040 >> 2] = 32'h01020304;

        //         ld    addr        we    wdata        rd sd st  drdata
        vecs[0] = '{1'b1, 32'h104,  4'h0, 32'h0,        0, 0, 3, 32'hCAFEF00D};
        vecs[1] = '{1'b0, 32'h203,  4'h4, 32'h00AB0000, 4, 0, 6, 32'hCAFEF00D};
        vecs[2] = '{1'b0, 32'h010,  4'hF, 32'h11223344, 0, 0, 2, 32'hCAFEF00D};
        vecs[3] = '{1'b1, 32'h010,  4'h0, 32'h0,        0, 0, 3, 32'h11223344};
        vecs[4] = '{1'b1, 32'h200,  4'h0, 32'h0,        1, 2, 6, 32'h55AB7788};
        vecs[5] = '{1'b1, 32'h040,  4'h3, 32'h0000BEEF, 0, 0, 2, 32'h55AB7788};
        vecs[6] = '{1'b1, 32'h042,  4'h0, 32'h0,        0, 1, 4, 32'h0102BEEF};
        vecs[7] = '{1'b0, 32'h1234, 4'h0, 32'h9999,     0, 0, 0, 32'h0102BEEF};

        repeat (2) @(negedge clk);
        #1;
        chk("rst.req_valid", 32'(req_valid), 32'd0);
        chk("rst.req_addr", req_addr, 32'h0);
        chk("rst.req_we", 32'(req_we), 32'h0);
        chk("rst.req_wdata", req_wdata, 32'h0);
        chk("rst.drdata", drdata, 32'h0);
        chk("rst.bus_err", 32'(bus_err), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            ref_step(vecs[i].ld, vecs[i].a, vecs[i].we, vecs[i].wd, vecs[i].rdly, vecs[i].sdly, st);
            exp_drd = vecs[i].exp_d;
            do_access($sformatf("vec%0d", i), vecs[i].ld, vecs[i].a, vecs[i].we, vecs[i].wd,
                      vecs[i].rdly, vecs[i].sdly, vecs[i].exp_st, vecs[i].exp_d);
        end

        mem_rd = 1'b0; dwe = 4'h0;
        s_seen = 0; v_seen = 0;
        for (int i = 0; i < 20; i++) begin
            daddr = $urandom; dwdata = $urandom;
            #1;
            if (stall) s_seen = 1;
            if (req_valid) v_seen = 1;
            @(negedge clk);
        end
        chk("alu.stall_seen", 32'(s_seen), 32'd0);
        chk("alu.valid_seen", 32'(v_seen), 32'd0);
        chk("alu.drdata_kept", drdata, exp_drd);

        mem_rd = 1'b1; daddr = 32'h80; dwe = 4'h0;
        @(negedge clk);
        chk("rstwait.req_valid_req", 32'(req_valid), 32'd1);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        chk("rstwait.stall_wait", 32'(stall), 32'd1);
        reset_n = 1'b0; mem_rd = 1'b0;
        #1;
        chk("rstwait.req_valid_rst", 32'(req_valid), 32'd0);
        chk("rstwait.drdata_rst", drdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'h12345678;
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        chk("rstwait.drdata_after", drdata, 32'h0);
        chk("rstwait.req_valid_after", 32'(req_valid), 32'd0);
        chk("rstwait.stall_after", 32'(stall), 32'd0);
        exp_drd = 32'h0;
        @(negedge clk);

`ifdef DMEM_TIMEOUT_EN
        mem_rd = 1'b1; dwe = 4'h0; daddr = 32'h300; req_ready = 1'b0; rsp_valid = 1'b0;
        st = 0; done = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            #1;
            if (stall) st++; else done = 1;
            if (!done) @(negedge clk);
        end
        chk("tmo.stall_cycles", 32'(st), 32'd9);
        chk("tmo.drdata", drdata, 32'h0);
        chk("tmo.bus_err", 32'(bus_err), 32'd1);
        chk("tmo.req_valid", 32'(req_valid), 32'd0);
        @(negedge clk);
        exp_drd = 32'h0; exp_err = 1'b1;
        ref_step(1'b1, 32'h104, 4'h0, 32'h0, 0, 0, st);
        do_access("tmo.good", 1'b1, 32'h104, 4'h0, 32'h0, 0, 0, st, exp_drd);
`else
        done = 0;
`endif

        for (int n = 0; n < 40; n++) begin
            int kind, rd, sd;
            logic ld;
            logic [3:0] we;
            logic [31:0] a, wd;
            kind = $urandom_range(0, 2);
            a = $urandom_range(0, 255);
            rd = $urandom_range(0, MAXD);
            sd = $urandom_range(0, MAXD);
            wd = $urandom;
            we = 4'h0; ld = 1'b0;
            if (kind == 0) ld = 1'b1;
            else if (kind == 1) begin
                we = 4'($urandom_range(1, 15));
                ld = 1'($urandom_range(0, 1));
            end
            ref_step(ld, a, we, wd, rd, sd, st);
            do_access($sformatf("rnd%0d", n), ld, a, we, wd, rd, sd, st, exp_drd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
